// File: rtl/cpu_bus_arbiter.sv
// Round-robin arbiter that multiplexes N_CPU cores onto one external read/write bus.
// It supports a bus lock for atomic sequences and a watchdog that fires when a transfer never completes.
//
//   state | meaning
//   IDLE  | no transfer; pick the next owner (only the lock owner while a lock is held)
//   XFER  | external strobe asserted and frozen; waiting for matching done or watchdog
//   DONE  | one-cycle done pulse to owner; lock retention decided here
module cpu_bus_arbiter #(
  parameter int N_CPU  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TMO_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CPU-1:0]        cpu_read_q,
  input  logic [N_CPU-1:0]        cpu_write_q,
  input  logic [N_CPU-1:0]        cpu_lock,
  input  logic [N_CPU*ADDR_W-1:0] cpu_addr,
  input  logic [N_CPU*DATA_W-1:0] cpu_wdata,
  output logic [N_CPU-1:0]        cpu_grant,
  output logic [N_CPU-1:0]        cpu_read_dn,
  output logic [N_CPU-1:0]        cpu_write_dn,
  output logic [DATA_W-1:0]       cpu_rdata,
  output logic                    read_q,
  output logic                    write_q,
  output logic [ADDR_W-1:0]       addr_out,
  output logic [DATA_W-1:0]       data_out,
  input  logic [DATA_W-1:0]       data_in,
  input  logic                    read_dn,
  input  logic                    write_dn,
  output logic                    bus_busy,
  output logic                    tmo_err
);
  localparam int IDX_W = $clog2(N_CPU);

  typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, DONE = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  owner_q, owner_d, rr_q, rr_d, win, sel, owner_nxt;
  logic              wr_op_q, wr_op_d, lock_q, lock_d, tmo_q, tmo_d;
  logic              rd_stb_q, rd_stb_d, wr_stb_q, wr_stb_d;
  logic [TMO_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [N_CPU-1:0]  rd_dn_q, rd_dn_d, wr_dn_q, wr_dn_d, pending, owner_oh;
  logic              found, go, done_hit;

  assign pending   = cpu_read_q | cpu_write_q;
  assign owner_oh  = N_CPU'(1) << owner_q;
  assign owner_nxt = (owner_q == IDX_W'(N_CPU - 1)) ? '0 : owner_q + 1'b1;
  assign cnt_inc   = cnt_q + 1'b1;
  assign done_hit  = wr_op_q ? write_dn : read_dn;

  always_comb begin : arb_search
    logic [IDX_W-1:0] idx;
    idx   = '0;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < N_CPU; k++) begin
      idx = IDX_W'((int'(rr_q) + k) % N_CPU);
      if (!found && pending[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // A held lock bypasses arbitration entirely: only the lock owner may start.
  assign sel = lock_q ? owner_q : win;
  assign go  = lock_q ? pending[owner_q] : found;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_d     = rr_q;
    wr_op_d  = wr_op_q;
    lock_d   = lock_q;
    rd_stb_d = rd_stb_q;
    wr_stb_d = wr_stb_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    rd_dn_d  = '0;
    wr_dn_d  = '0;
    tmo_d    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (go) begin
          state_d  = XFER;
          owner_d  = sel;
          wr_op_d  = cpu_write_q[sel];
          wr_stb_d = cpu_write_q[sel];
          rd_stb_d = !cpu_write_q[sel];
          addr_d   = cpu_addr[sel*ADDR_W +: ADDR_W];
          wdata_d  = cpu_wdata[sel*DATA_W +: DATA_W];
        end else if (lock_q && !cpu_lock[owner_q]) begin
          lock_d = 1'b0;
        end
      end
      XFER: begin
        cnt_d = cnt_inc;
        // A matching done in the expiry cycle still counts as a normal completion.
        if (done_hit || (&cnt_inc)) begin
          state_d  = DONE;
          rd_stb_d = 1'b0;
          wr_stb_d = 1'b0;
          cnt_d    = '0;
          if (wr_op_q) begin
            wr_dn_d = owner_oh;
          end else begin
            rd_dn_d = owner_oh;
            rdata_d = done_hit ? data_in : '0;
          end
          if (!done_hit) begin
            tmo_d  = 1'b1;
            lock_d = 1'b0;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        rr_d    = owner_nxt;
        lock_d  = cpu_lock[owner_q] && !tmo_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_q     <= '0;
      wr_op_q  <= 1'b0;
      lock_q   <= 1'b0;
      rd_stb_q <= 1'b0;
      wr_stb_q <= 1'b0;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rd_dn_q  <= '0;
      wr_dn_q  <= '0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_q     <= rr_d;
      wr_op_q  <= wr_op_d;
      lock_q   <= lock_d;
      rd_stb_q <= rd_stb_d;
      wr_stb_q <= wr_stb_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      rd_dn_q  <= rd_dn_d;
      wr_dn_q  <= wr_dn_d;
      tmo_q    <= tmo_d;
    end
  end

  assign bus_busy     = (state_q != IDLE) || lock_q;
  assign cpu_grant    = bus_busy ? owner_oh : '0;
  assign cpu_read_dn  = rd_dn_q;
  assign cpu_write_dn = wr_dn_q;
  assign cpu_rdata    = rdata_q;
  assign read_q       = rd_stb_q;
  assign write_q      = wr_stb_q;
  assign addr_out     = addr_q;
  assign data_out     = wdata_q;
  assign tmo_err      = tmo_q;
endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Randomized bench for cpu_bus_arbiter: a transaction-level reference model is compared every cycle,
// and directed scenarios pin the model with literal expectations.
module tb_cpu_bus_arbiter;
  localparam int N   = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 255;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    cpu_read_q, cpu_write_q, cpu_lock;
  logic [N*AW-1:0] cpu_addr;
  logic [N*DW-1:0] cpu_wdata;
  logic [N-1:0]    cpu_grant, cpu_read_dn, cpu_write_dn;
  logic [DW-1:0]   cpu_rdata, data_out, data_in;
  logic [AW-1:0]   addr_out;
  logic            read_q, write_q, read_dn, write_dn, bus_busy, tmo_err;

  cpu_bus_arbiter #(.N_CPU(N), .ADDR_W(AW), .DATA_W(DW), .TMO_W(8)) dut (
    .clk(clk), .rst(rst),
    .cpu_read_q(cpu_read_q), .cpu_write_q(cpu_write_q), .cpu_lock(cpu_lock),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_grant(cpu_grant), .cpu_read_dn(cpu_read_dn), .cpu_write_dn(cpu_write_dn),
    .cpu_rdata(cpu_rdata), .read_q(read_q), .write_q(write_q),
    .addr_out(addr_out), .data_out(data_out), .data_in(data_in),
    .read_dn(read_dn), .write_dn(write_dn), .bus_busy(bus_busy), .tmo_err(tmo_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: phase 0 = bus free, 1 = transfer on the bus, 2 = reporting completion.
  int            m_phase, m_owner, m_rr, m_wait, who;
  bit            m_wr, m_locked, hit, prev_tmo, started;
  logic [N-1:0]  e_rdn, e_wdn, eg;
  logic          e_tmo;
  logic [DW-1:0] e_rdata, e_data;
  logic [AW-1:0] e_addr;
  bit            ok;

  always @(posedge clk) begin
    started = 1'b1;
    if (rst) begin
      m_phase = 0; m_owner = 0; m_rr = 0; m_wait = 0; m_wr = 0; m_locked = 0;
      e_rdn = '0; e_wdn = '0; e_tmo = 1'b0; e_rdata = '0;
    end else begin
      prev_tmo = e_tmo;
      e_rdn = '0; e_wdn = '0; e_tmo = 1'b0;
      if (m_phase == 0) begin
        who = -1;
        if (m_locked) begin
          if (cpu_read_q[m_owner] || cpu_write_q[m_owner]) who = m_owner;
          else if (!cpu_lock[m_owner]) m_locked = 0;
        end else begin
          for (int k = 0; k < N; k++)
            if (who < 0 && (cpu_read_q[(m_rr + k) % N] || cpu_write_q[(m_rr + k) % N]))
              who = (m_rr + k) % N;
        end
        if (who >= 0) begin
          m_owner = who;
          m_wr    = cpu_write_q[who];
          e_addr  = cpu_addr[who*AW +: AW];
          e_data  = cpu_wdata[who*DW +: DW];
          m_wait  = 0;
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        m_wait++;
        hit = m_wr ? write_dn : read_dn;
        if (hit || m_wait == TMO) begin
          m_phase = 2;
          if (m_wr) e_wdn[m_owner] = 1'b1;
          else begin
            e_rdn[m_owner] = 1'b1;
            e_rdata = hit ? data_in : '0;
          end
          if (!hit) begin e_tmo = 1'b1; m_locked = 0; end
          m_rr = (m_owner + 1) % N;
        end
      end else begin
        m_phase  = 0;
        m_locked = cpu_lock[m_owner] && !prev_tmo;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      eg = (m_phase != 0 || m_locked) ? (N'(1) << m_owner) : '0;
      ok = (cpu_grant === eg) && (read_q === (m_phase == 1 && !m_wr)) &&
           (write_q === (m_phase == 1 && m_wr)) && (bus_busy === (m_phase != 0 || m_locked)) &&
           (cpu_read_dn === e_rdn) && (cpu_write_dn === e_wdn) && (tmo_err === e_tmo);
      if (m_phase == 1) ok &= (addr_out === e_addr);
      if (m_phase == 1 && m_wr) ok &= (data_out === e_data);
      if (e_rdn != '0) ok &= (cpu_rdata === e_rdata);
      n_cmp++;
      if (!ok) begin
        n_bad++;
        if (n_bad <= 10)
          $display("FAIL cycle_model t=%0t grant=%b/%b rq=%b wq=%b busy=%b rdn=%b/%b wdn=%b/%b tmo=%b/%b addr=%h/%h rdata=%h/%h",
                   $time, cpu_grant, eg, read_q, write_q, bus_busy, cpu_read_dn, e_rdn,
                   cpu_write_dn, e_wdn, tmo_err, e_tmo, addr_out, e_addr, cpu_rdata, e_rdata);
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  bit            rnd, rearm_en, auto_unlock, use_fix, prev_stb;
  int            resp_cnt, lat, silent, pick, n, n_stb;
  logic [DW-1:0] fix_data;
  logic [N-1:0]  rearm_pend;
  logic [AW-1:0] seen_addr;
  int            log_q[$];
  int            rr_exp[4] = '{0, 2, 6, 0};
  int            lk_exp[3] = '{3, 2, 0};

  // One cycle of stimulus: cores react to done pulses, bus responder answers strobes.
  task automatic step();
    @(negedge clk);
    rst = 1'b0;
    cpu_read_q |= rearm_pend;
    rearm_pend = '0;
    for (int i = 0; i < N; i++) begin
      if (cpu_read_dn[i]) begin
        cpu_read_q[i] = 1'b0;
        if (rearm_en) rearm_pend[i] = 1'b1;
      end
      if (cpu_write_dn[i]) cpu_write_q[i] = 1'b0;
      if (auto_unlock && !cpu_read_q[i] && !cpu_write_q[i]) cpu_lock[i] = 1'b0;
    end
    if ((read_q || write_q) && !prev_stb)
      for (int i = 0; i < N; i++) if (cpu_grant[i]) log_q.push_back(i*2 + int'(write_q));
    prev_stb = read_q || write_q;
    read_dn  = 1'b0;
    write_dn = 1'b0;
    data_in  = use_fix ? fix_data : DW'($urandom);
    if (silent > 0) silent--;
    else if (read_q || write_q) begin
      if (resp_cnt == 0) begin
        if (read_q) read_dn = 1'b1; else write_dn = 1'b1;
        resp_cnt = rnd ? $urandom_range(5) : lat;
      end else resp_cnt--;
    end
    if (rnd) begin
      if ((read_q || write_q) && $urandom_range(9) == 0) begin
        if (read_q) write_dn = 1'b1; else read_dn = 1'b1;
      end
      for (int i = 0; i < N; i++) begin
        if (!cpu_read_q[i] && !cpu_write_q[i] && $urandom_range(7) == 0) begin
          cpu_addr[i*AW +: AW]  = AW'($urandom);
          cpu_wdata[i*DW +: DW] = DW'($urandom);
          pick = $urandom_range(3, 1);
          cpu_read_q[i]  = pick[0];
          cpu_write_q[i] = pick[1];
        end else if ($urandom_range(80) == 0) begin
          cpu_read_q[i] = 1'b0; cpu_write_q[i] = 1'b0;
        end
        if ($urandom_range(20) == 0) cpu_lock[i] = ~cpu_lock[i];
      end
      if ($urandom_range(900) == 0) rst = 1'b1;
      if ($urandom_range(1500) == 0) silent = 300;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; cpu_read_q = '0; cpu_write_q = '0; cpu_lock = '0;
    cpu_addr = '0; cpu_wdata = '0; data_in = '0; read_dn = 1'b0; write_dn = 1'b0;
    rnd = 0; rearm_en = 0; auto_unlock = 0; use_fix = 0; prev_stb = 0;
    resp_cnt = 0; lat = 0; silent = 0; fix_data = '0; rearm_pend = '0;
    repeat (3) @(negedge clk);
    chk("reset_grant", 64'(cpu_grant), 64'(0));
    chk("reset_busy", 64'(bus_busy), 64'(0));
    chk("reset_strobes", 64'({read_q, write_q, tmo_err}), 64'(0));
    step();

    // Round robin: cores 0,1,3 keep requesting.
    log_q.delete();
    rearm_en = 1;
    cpu_read_q = 4'b1011;
    n = 0;
    while (log_q.size() < 4 && n < 60) begin step(); n++; end
    rearm_en = 0; rearm_pend = '0; cpu_read_q = '0;
    repeat (8) step();
    chk("rr_count", 64'(log_q.size()), 64'(4));
    for (int i = 0; i < 4 && i < log_q.size(); i++) chk("rr_order", 64'(log_q[i]), 64'(rr_exp[i]));

    // Single read from core 2, bus answers in the third strobe cycle.
    cpu_addr[2*AW +: AW] = 32'h100;
    use_fix = 1; fix_data = 32'hCAFE; resp_cnt = 2;
    cpu_read_q[2] = 1'b1;
    n = 0;
    do begin
      step(); n++;
      if (n == 1) seen_addr = addr_out;
    end while (cpu_read_dn == '0 && cpu_write_dn == '0 && n < 12);
    chk("rd_latency", 64'(n), 64'(4));
    chk("rd_addr", 64'(seen_addr), 64'(32'h100));
    chk("rd_dn", 64'(cpu_read_dn), 64'(4'b0100));
    chk("rd_data", 64'(cpu_rdata), 64'(32'hCAFE));
    use_fix = 0;
    repeat (4) step();

    // Same core with read and write: write goes first.
    log_q.delete();
    cpu_read_q[0] = 1'b1; cpu_write_q[0] = 1'b1;
    repeat (12) step();
    chk("rw_count", 64'(log_q.size()), 64'(2));
    if (log_q.size() == 2) begin
      chk("rw_first_write", 64'(log_q[0]), 64'(1));
      chk("rw_then_read", 64'(log_q[1]), 64'(0));
    end

    // Locked write-then-read on core 1 while core 0 waits.
    log_q.delete();
    auto_unlock = 1;
    cpu_lock[1] = 1'b1; cpu_write_q[1] = 1'b1; cpu_read_q[1] = 1'b1; cpu_read_q[0] = 1'b1;
    repeat (16) step();
    auto_unlock = 0;
    chk("lock_count", 64'(log_q.size()), 64'(3));
    for (int i = 0; i < 3 && i < log_q.size(); i++) chk("lock_order", 64'(log_q[i]), 64'(lk_exp[i]));

    // Watchdog: core 3 write never acknowledged.
    silent = 1000;
    cpu_write_q[3] = 1'b1;
    n = 0; n_stb = 0;
    do begin
      step(); n++;
      if (write_q) n_stb++;
    end while (!tmo_err && n < 400);
    chk("tmo_wait_cycles", 64'(n_stb), 64'(TMO));
    chk("tmo_pulse", 64'(tmo_err), 64'(1));
    chk("tmo_done_pulse", 64'(cpu_write_dn), 64'(4'b1000));
    silent = 0;
    step();
    chk("tmo_idle_busy", 64'(bus_busy), 64'(0));

    // Reset in the middle of a read, then the held request is served again.
    resp_cnt = 5;
    cpu_read_q[2] = 1'b1;
    step();
    step();
    rst = 1'b1;
    step();
    chk("rst_read_q", 64'(read_q), 64'(0));
    chk("rst_grant", 64'(cpu_grant), 64'(0));
    chk("rst_busy", 64'(bus_busy), 64'(0));
    n = 0;
    do begin step(); n++; end while (cpu_read_dn == '0 && n < 20);
    chk("rst_then_served", 64'(cpu_read_dn), 64'(4'b0100));
    repeat (4) step();

    rnd = 1;
    repeat (4000) step();
    rnd = 0;
    cpu_read_q = '0; cpu_write_q = '0; cpu_lock = '0;
    repeat (5) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
